// File: rtl/ecc_pkg.sv
// ecc_pkg: shared SEC-DED classes, sizes and the data-bit position table.
package ecc_pkg;
    localparam int DATA_W = 32;
    localparam int HAM_POS_MAX = 38;
    typedef enum logic [1:0] {CLEAN, CE_DATA, CE_CHK, UE} ecc_class_e;
    // Hamming position of data bit i: the i-th non-power-of-two position from 3
    localparam logic [5:0] DATA_POS [DATA_W] = '{
        6'd3,  6'd5,  6'd6,  6'd7,  6'd9,  6'd10, 6'd11, 6'd12,
        6'd13, 6'd14, 6'd15, 6'd17, 6'd18, 6'd19, 6'd20, 6'd21,
        6'd22, 6'd23, 6'd24, 6'd25, 6'd26, 6'd27, 6'd28, 6'd29,
        6'd30, 6'd31, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38
    };
endpackage

// File: rtl/ecc_classify.sv
// ecc_classify: classifies a word from its Hamming syndrome and builds the data bit-flip mask.
module ecc_classify
    import ecc_pkg::*;
(
    input  logic [6:0]        synd_a,
    output ecc_class_e        cls,
    output logic [DATA_W-1:0] flip_mask
);
    logic [5:0] s;
    logic       p;
    logic       pow2;
    assign s = synd_a[5:0];
    assign p = synd_a[6];
    assign pow2 = (s & (s - 6'd1)) == 6'd0;
    always_comb begin
        cls = (s == 6'd0 && !p) ? CLEAN :
              !p                 ? UE :
              pow2               ? CE_CHK :
              (s > 6'(HAM_POS_MAX)) ? UE : CE_DATA;
    end
    for (genvar i = 0; i < DATA_W; i++) begin : g_mask
        assign flip_mask[i] = (cls == CE_DATA) && (s == DATA_POS[i]);
    end
endmodule

// File: rtl/ecc_correct_stage.sv
// ecc_correct_stage: two-stage SEC-DED correction with error counters, first-error log
// and a single-entry scrub write-back request.
module ecc_correct_stage
    import ecc_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [31:0]       data_Cache,
    input  logic [6:0]        synd_A,
    input  logic [7:0]        synd_B,
    input  logic              par_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_ue,
    output logic              out_ce,
    output logic              chk_err,
    output logic [CNT_W-1:0]  ce_cnt,
    output logic [CNT_W-1:0]  ue_cnt,
    output logic              log_valid,
    output logic [ADDR_W-1:0] log_addr,
    input  logic              cnt_clr,
    output logic              scrub_req,
    output logic [ADDR_W-1:0] scrub_addr,
    output logic [31:0]       scrub_data,
    input  logic              scrub_ack,
    output logic              scrub_drop
);
    typedef enum logic {IDLE, REQ} scrub_st_e;
    ecc_class_e        in_cls, s1_cls, s2_cls;
    logic [DATA_W-1:0] in_mask, s1_mask, s1_data;
    logic [ADDR_W-1:0] s1_addr;
    logic              s1_valid, s1_bbad, s2_bbad, s2_adv, hs, ce_trig;
    scrub_st_e         st;
    ecc_classify u_classify (.synd_a(synd_A), .cls(in_cls), .flip_mask(in_mask));
    assign s2_adv    = !out_valid || out_ready;
    assign in_ready  = !s1_valid || s2_adv;
    assign hs        = out_valid && out_ready;
    assign ce_trig   = hs && s2_cls == CE_DATA;
    assign scrub_req = st == REQ;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_cls   <= CLEAN;
            s1_mask  <= '0;
            s1_data  <= '0;
            s1_addr  <= '0;
            s1_bbad  <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            s1_cls   <= in_cls;
            s1_mask  <= in_mask;
            s1_data  <= data_Cache;
            s1_addr  <= in_addr;
            s1_bbad  <= |synd_B || par_b;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
            out_ce    <= 1'b0;
            out_ue    <= 1'b0;
            s2_cls    <= CLEAN;
            s2_bbad   <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= s1_data ^ s1_mask;
                out_addr <= s1_addr;
                out_ce   <= s1_cls == CE_DATA || s1_cls == CE_CHK;
                out_ue   <= s1_cls == UE;
                s2_cls   <= s1_cls;
                s2_bbad  <= s1_bbad;
            end
        end
    end
    // Clear outranks any same-cycle increment or log capture
    always_ff @(posedge clk) begin
        if (!rst_n || cnt_clr) begin
            ce_cnt    <= '0;
            ue_cnt    <= '0;
            log_valid <= 1'b0;
            log_addr  <= '0;
            chk_err   <= 1'b0;
        end else begin
            if (hs && out_ce && !(&ce_cnt))
                ce_cnt <= ce_cnt + CNT_W'(1);
            if (hs && out_ue && !(&ue_cnt))
                ue_cnt <= ue_cnt + CNT_W'(1);
            if (hs && (out_ce || out_ue) && !log_valid) begin
                log_valid <= 1'b1;
                log_addr  <= out_addr;
            end
            chk_err <= chk_err || (hs && s2_cls == CLEAN && s2_bbad);
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st         <= IDLE;
            scrub_addr <= '0;
            scrub_data <= '0;
            scrub_drop <= 1'b0;
        end else begin
            scrub_drop <= ce_trig && st == REQ && !scrub_ack;
            if (ce_trig && (st == IDLE || scrub_ack)) begin
                st         <= REQ;
                scrub_addr <= out_addr;
                scrub_data <= out_data;
            end else if (scrub_ack) begin
                st <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_ecc_correct_stage.sv
// tb_ecc_correct_stage: directed and random checks of ecc_correct_stage against a
// behavioural SEC-DED / pipeline / counter model.
module tb_ecc_correct_stage;
    localparam int CNT_W = 4;
    localparam int CMAX = (1 << CNT_W) - 1;
    localparam int M_CLEAN = 0, M_DATA = 1, M_CHK = 2, M_UE = 3;
    logic clk = 1'b0, rst_n = 1'b0;
    logic in_valid = 1'b0, in_ready, par_b = 1'b0, out_valid, out_ready = 1'b1;
    logic [31:0] in_addr = '0, data_Cache = '0, out_data, out_addr, log_addr, scrub_addr, scrub_data;
    logic [6:0] synd_A = '0;
    logic [7:0] synd_B = '0;
    logic out_ue, out_ce, chk_err, log_valid, cnt_clr = 1'b0, scrub_req, scrub_ack = 1'b0, scrub_drop;
    logic [CNT_W-1:0] ce_cnt, ue_cnt;
    int vecs = 0, errs = 0;

    ecc_correct_stage #(.ADDR_W(32), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
        .data_Cache(data_Cache), .synd_A(synd_A), .synd_B(synd_B), .par_b(par_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
        .out_ue(out_ue), .out_ce(out_ce), .chk_err(chk_err), .ce_cnt(ce_cnt), .ue_cnt(ue_cnt),
        .log_valid(log_valid), .log_addr(log_addr), .cnt_clr(cnt_clr), .scrub_req(scrub_req),
        .scrub_addr(scrub_addr), .scrub_data(scrub_data), .scrub_ack(scrub_ack), .scrub_drop(scrub_drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Data bit index of a Hamming position: positions below it minus the power-of-two slots
    function automatic int pos_to_bit(input int s);
        int n;
        n = 0;
        for (int k = 1; k <= s; k = k * 2) n++;
        return s - n - 1;
    endfunction

    function automatic void classify(input logic [6:0] sa, input logic [31:0] d,
                                     output int cls, output logic [31:0] od);
        int s;
        s = int'(sa[5:0]);
        od = d;
        if (!sa[6]) cls = (s == 0) ? M_CLEAN : M_UE;
        else if (s == 0 || s == 1 || s == 2 || s == 4 || s == 8 || s == 16 || s == 32) cls = M_CHK;
        else if (s > 38) cls = M_UE;
        else begin
            cls = M_DATA;
            od = d ^ (32'h1 << pos_to_bit(s));
        end
    endfunction

    typedef struct {
        logic [31:0] data;
        logic [31:0] addr;
        int cls;
        bit bbad;
        int t;
    } item_t;
    item_t q[$];
    int cyc = 0, m_ce = 0, m_ue = 0;
    bit m_logv = 0, m_chk = 0, m_busy = 0, m_drop = 0;
    logic [31:0] m_loga = '0, m_sa = '0, m_sd = '0;

    // Model: advances on each rising edge using the pre-edge inputs and handshakes
    initial forever begin
        item_t it, ni;
        bit hs, trig;
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            m_ce = 0; m_ue = 0; m_logv = 0; m_loga = '0; m_chk = 0;
            m_busy = 0; m_sa = '0; m_sd = '0; m_drop = 0;
        end else begin
            hs = out_valid && out_ready && q.size() > 0;
            if (hs) it = q.pop_front();
            if (hs && it.cls != M_CLEAN) begin
                if (it.cls == M_UE) m_ue = (m_ue == CMAX) ? CMAX : m_ue + 1;
                else m_ce = (m_ce == CMAX) ? CMAX : m_ce + 1;
                if (!m_logv) begin m_logv = 1; m_loga = it.addr; end
            end
            if (hs && it.cls == M_CLEAN && it.bbad) m_chk = 1;
            if (cnt_clr) begin m_ce = 0; m_ue = 0; m_logv = 0; m_loga = '0; m_chk = 0; end
            trig = hs && it.cls == M_DATA;
            m_drop = trig && m_busy && !scrub_ack;
            if (trig && (!m_busy || scrub_ack)) begin
                m_busy = 1; m_sa = it.addr; m_sd = it.data;
            end else if (scrub_ack) m_busy = 0;
            if (in_valid && in_ready) begin
                classify(synd_A, data_Cache, ni.cls, ni.data);
                ni.addr = in_addr;
                ni.bbad = (synd_B != 0) || par_b;
                ni.t = cyc;
                q.push_back(ni);
            end
        end
        cyc++;
    end

    // Compare on the falling edge, well clear of the register updates
    initial forever begin
        bit exp_ov;
        @(negedge clk);
        if (rst_n) begin
            exp_ov = q.size() > 0 && (cyc - q[0].t) >= 2;
            chk("out_valid", {31'b0, out_valid}, {31'b0, exp_ov});
            chk("in_ready", {31'b0, in_ready}, {31'b0, q.size() < 2 || out_ready});
            if (exp_ov && out_valid) begin
                chk("out_data", out_data, q[0].data);
                chk("out_addr", out_addr, q[0].addr);
                chk("out_ce", {31'b0, out_ce}, {31'b0, q[0].cls == M_DATA || q[0].cls == M_CHK});
                chk("out_ue", {31'b0, out_ue}, {31'b0, q[0].cls == M_UE});
            end
            chk("ce_cnt", 32'(ce_cnt), m_ce);
            chk("ue_cnt", 32'(ue_cnt), m_ue);
            chk("log_valid", {31'b0, log_valid}, {31'b0, m_logv});
            chk("log_addr", log_addr, m_loga);
            chk("chk_err", {31'b0, chk_err}, {31'b0, m_chk});
            chk("scrub_req", {31'b0, scrub_req}, {31'b0, m_busy});
            chk("scrub_drop", {31'b0, scrub_drop}, {31'b0, m_drop});
            if (m_busy) begin
                chk("scrub_addr", scrub_addr, m_sa);
                chk("scrub_data", scrub_data, m_sd);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [6:0] sa,
                        input logic [7:0] sb, input logic pb);
        int n;
        in_addr = a; data_Cache = d; synd_A = sa; synd_B = sb; par_b = pb; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin tick; n++; end
        if (n == 20) chk("send_timeout", 32'd1, 32'd0);
        tick;
        in_valid = 1'b0; synd_B = '0; par_b = 1'b0;
    endtask

    task automatic wait_out;
        int n;
        n = 0;
        while (!out_valid && n < 20) begin tick; n++; end
        if (n == 20) chk("out_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int cls, acc, drops;
        logic [31:0] od, dv;
        classify({1'b1, 6'd3}, 32'h0, cls, od);
        chk("model_pos3", od, 32'h0000_0001);
        classify({1'b1, 6'd38}, 32'h0, cls, od);
        chk("model_pos38", od, 32'h8000_0000);
        classify({1'b1, 6'd12}, 32'hFFFF_FFFF, cls, od);
        chk("model_pos12", od, 32'hFFFF_FF7F);
        classify({1'b1, 6'd16}, 32'h0, cls, od);
        chk("model_chk16", cls, M_CHK);
        classify({1'b1, 6'd40}, 32'h0, cls, od);
        chk("model_ue40", cls, M_UE);
        classify({1'b0, 6'd5}, 32'h0, cls, od);
        chk("model_ue_dbl", cls, M_UE);

        tick; tick;
        rst_n = 1'b1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_addr", out_addr, 32'd0);
        chk("rst_out_flags", {30'b0, out_ce, out_ue}, 32'd0);
        chk("rst_cnts", {ce_cnt, ue_cnt}, 32'd0);
        chk("rst_log", {31'b0, log_valid} | log_addr, 32'd0);
        chk("rst_scrub", {30'b0, scrub_req, scrub_drop} | scrub_addr | scrub_data, 32'd0);
        chk("rst_chk_err", {31'b0, chk_err}, 32'd0);

        send(32'h100, 32'hDEAD_BEEF, 7'd0, 8'd0, 1'b0);
        wait_out;
        chk("clean_data", out_data, 32'hDEAD_BEEF);
        chk("clean_flags", {30'b0, out_ce, out_ue}, 32'd0);
        tick;
        chk("clean_cnts", {ce_cnt, ue_cnt}, 32'd0);

        send(32'h200, 32'h0, {1'b1, 6'd3}, 8'd0, 1'b0);
        wait_out;
        chk("ce_data", out_data, 32'h0000_0001);
        chk("ce_flag", {31'b0, out_ce}, 32'd1);
        tick;
        chk("ce_cnt1", 32'(ce_cnt), 32'd1);
        chk("ce_log", log_addr, 32'h200);
        chk("scrub_data1", scrub_data, 32'h0000_0001);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("scrub_hold", {31'b0, scrub_req}, 32'd1);
        end
        scrub_ack = 1'b1; tick; scrub_ack = 1'b0;
        chk("scrub_release", {31'b0, scrub_req}, 32'd0);
        cnt_clr = 1'b1; tick; cnt_clr = 1'b0;
        chk("clr_ce", 32'(ce_cnt), 32'd0);

        send(32'h300, 32'h1234_5678, {1'b0, 6'd5}, 8'd0, 1'b0);
        wait_out;
        chk("ue_flag", {31'b0, out_ue}, 32'd1);
        chk("ue_raw", out_data, 32'h1234_5678);
        tick;
        chk("ue_cnt1", 32'(ue_cnt), 32'd1);
        chk("ue_log", log_addr, 32'h300);
        chk("ue_no_scrub", {31'b0, scrub_req}, 32'd0);

        in_valid = 1'b1; in_addr = 32'h400; data_Cache = 32'h0; synd_A = {1'b1, 6'd5};
        tick;
        in_addr = 32'h404; data_Cache = 32'hFFFF_FFFF; synd_A = {1'b1, 6'd38};
        tick;
        in_valid = 1'b0;
        drops = 0;
        for (int i = 0; i < 6; i++) begin tick; drops += int'(scrub_drop); end
        chk("drop_once", drops, 32'd1);
        chk("ce_cnt2", 32'(ce_cnt), 32'd2);
        chk("scrub_first", scrub_data, 32'h0000_0002);
        chk("scrub_first_a", scrub_addr, 32'h400);
        scrub_ack = 1'b1; tick; scrub_ack = 1'b0;

        send(32'h500, 32'h55AA_55AA, 7'd0, 8'h10, 1'b0);
        wait_out;
        chk("chk_clean", {30'b0, out_ce, out_ue}, 32'd0);
        tick;
        chk("chk_err_set", {31'b0, chk_err}, 32'd1);

        out_ready = 1'b0; in_valid = 1'b1; synd_A = '0; dv = 32'hA000_0000; acc = 0;
        for (int i = 0; i < 4; i++) begin
            data_Cache = dv; in_addr = dv;
            if (in_ready) begin acc++; dv++; end
            tick;
        end
        chk("stall_acc", acc, 32'd2);
        chk("stall_ready", {31'b0, in_ready}, 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            data_Cache = dv; in_addr = dv;
            if (in_ready) dv++;
            tick;
        end
        in_valid = 1'b0;
        repeat (4) tick;

        cnt_clr = 1'b1; tick; cnt_clr = 1'b0;
        in_valid = 1'b1; synd_A = {1'b1, 6'd0};
        repeat (CMAX + 2) tick;
        in_valid = 1'b0;
        repeat (4) tick;
        chk("ce_sat", 32'(ce_cnt), CMAX);
        in_addr = 32'h600; synd_A = {1'b0, 6'd9};
        send(32'h600, 32'h0, {1'b0, 6'd9}, 8'd0, 1'b0);
        wait_out;
        cnt_clr = 1'b1; tick; cnt_clr = 1'b0;
        chk("clr_ue", 32'(ue_cnt), 32'd0);
        chk("clr_log", {31'b0, log_valid}, 32'd0);
        chk("clr_ce_sat", 32'(ce_cnt), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            in_valid = $urandom_range(0, 9) < 7;
            out_ready = $urandom_range(0, 3) != 0;
            scrub_ack = $urandom_range(0, 9) < 3;
            cnt_clr = $urandom_range(0, 49) == 0;
            in_addr = $urandom;
            data_Cache = $urandom;
            synd_B = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'd0;
            par_b = $urandom_range(0, 7) == 0;
            case ($urandom_range(0, 3))
                0: synd_A = 7'd0;
                1: synd_A = {1'b1, 6'($urandom_range(3, 38))};
                2: synd_A = {1'b1, 6'(32'd1 << $urandom_range(0, 5)) & {6{$urandom_range(0, 5) != 0}}};
                default: synd_A = 7'($urandom);
            endcase
            if (i == 1500) begin
                rst_n = 1'b0; in_valid = 1'b0;
                tick;
                chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
                chk("mid_rst_ready", {31'b0, in_ready}, 32'd1);
                chk("mid_rst_scrub", {31'b0, scrub_req}, 32'd0);
                chk("mid_rst_cnt", 32'(ce_cnt), 32'd0);
                rst_n = 1'b1;
            end
            tick;
        end
        in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0; scrub_ack = 1'b0;
        repeat (5) tick;
        chk("drain", q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
